spi_receptor_param: RTL and testbench
=====================================

Name: spi_receptor_param

Overview:
- Parametrised SPI slave, successor to the fixed 16-bit receiver.
- Runs entirely on the system clock, which oversamples SCK/CS/MOSI.
- Adds configurable word width and words per transaction, a software-loadable TX buffer with a default-word fallback, an RX valid strobe and underrun/abort flags.
- Sits between the SPI pins and the local register/control logic.

Parameters:
- WIDTH, 16: bits per word (≥2).
- WORDS, 2: words per transaction; after the last word, SCK edges are ignored until CS rises.
- SYNC_STAGES, 2: synchroniser depth on SCK, CS and MOSI (≥2).
- DEFAULT_TX, 16'h0106 (WIDTH bits): word shifted out when the TX buffer is empty.

Ports:
- clk  in  1  system clock; must be ≥8× the SCK frequency.
- reset  in  1  asynchronous, active-high.
- CKP  in  1  SCK idle level; sampled only while CS is high.
- CPH  in  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- SCK  in  1  SPI clock, asynchronous to clk.
- CS  in  1  chip select, active-low.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- tx_data  in  WIDTH  next word to transmit.
- tx_load  in  1  write strobe for tx_data; honoured only when tx_ready=1.
- tx_ready  out  1  TX buffer empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- underrun  out  1  one-cycle strobe when DEFAULT_TX is used because the buffer was empty.
- abort  out  1  one-cycle strobe when CS rises mid-word.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset values: MISO=0, rx_data=0, rx_valid=0, underrun=0, abort=0, tx_ready=1, busy=0, state=IDLE, bit_cnt=0, word_cnt=0.
- Synchronisation: SCK, CS and MOSI each pass through SYNC_STAGES flops. SCK edges are detected against the previous synchronised sample. Pin-to-action latency is SYNC_STAGES+1 clk cycles.
- Edge selection:
  - sample edge = rising SCK when CKP==CPH, falling otherwise.
  - drive edge = the opposite SCK edge.
- States: IDLE, XFER, DONE.
- IDLE, on CS falling:
  - Load tx_shift from the buffer if full (tx_ready←1), else from DEFAULT_TX (pulse underrun).
  - If CPH=0, MISO←tx_shift MSB immediately.
  - bit_cnt←0, word_cnt←0, go to XFER.
- XFER, sample edge: rx_shift←{rx_shift[WIDTH-2:0],MOSI}, bit_cnt++.
- Word boundary (bit_cnt reaches WIDTH):
  - rx_data←assembled word, pulse rx_valid next cycle.
  - bit_cnt←0, word_cnt++.
  - If word_cnt==WORDS, go to DONE.
  - Otherwise reload tx_shift using the same buffer/default rule.
- XFER, drive edge:
  - CPH=0: MISO←next bit; the drive edge after a boundary outputs the new word's MSB.
  - CPH=1: each drive edge outputs the current bit, starting at the MSB.
- DONE: all SCK edges ignored; MISO holds its last value.
- CS rising in XFER or DONE: go to IDLE, MISO←0.
  - If 0<bit_cnt<WIDTH, the partial word is discarded (no rx_valid) and abort pulses.
  - An unconsumed TX buffer is kept.
- tx_load in the same cycle as a word-boundary reload: the reload sees the buffer state before the load. An empty buffer therefore yields DEFAULT_TX plus underrun, and the new word fills the buffer for the next word.
- tx_load while tx_ready=0: ignored, buffer unchanged.
- CKP/CPH changes while CS is low: ignored until the next CS fall, because the mode is latched on CS falling.
- Asynchronous reset mid-transfer: every register returns to its reset value immediately.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: bit 0 is shifted out first on MISO, and received bits fill rx_shift from the MSB downward (rx_shift←{MOSI,rx_shift[WIDTH-1:1]}), so rx_data is still bit-exact.
- Undefined: MSB-first in both directions, as described above.

Test Plan:
- Mode 0 (CKP=0, CPH=0), WIDTH=16, WORDS=2, buffer empty; master sends 16'hA5C3 then 16'h1234 -> MISO streams 16'h0106 twice; underrun pulses twice; rx_valid pulses twice with rx_data 16'hA5C3 then 16'h1234; busy falls after CS rises.
- Mode 3 (CKP=1, CPH=1), tx_load 16'hBEEF before CS falls, master sends 16'h00FF -> MISO shows 16'hBEEF MSB first, changing on falling SCK; rx_data=16'h00FF; no underrun; tx_ready=1 after CS falls.
- Modes 1 and 2 with master 16'h8001 -> rx_data=16'h8001 in both modes; each MISO bit is stable across the sample edge.
- CS rises after 7 bits -> abort pulses; no rx_valid; rx_data keeps its previous value; MISO=0; the next transaction receives 16'h5555 correctly.
- WORDS=2 but master clocks 40 bits -> exactly two rx_valid pulses; the extra 8 edges are ignored in DONE; MISO is frozen.
- tx_load 16'h1111 in the same cycle as the first word boundary with the buffer empty -> word 2 = DEFAULT_TX with underrun; 16'h1111 is sent as word 1 of the next transaction.

Source files
------------

// File: rtl/spi_receptor_param_if.sv
// rtl/spi_receptor_param_if.sv - SPI pin and local TX/RX signal bundle for spi_receptor_param
interface spi_receptor_param_if #(
    parameter int WIDTH = 16
);
    logic             CKP;
    logic             CPH;
    logic             SCK;
    logic             CS;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             underrun;
    logic             abort;
    logic             busy;

    modport slave (
        input  CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
        output MISO, tx_ready, rx_data, rx_valid, underrun, abort, busy
    );

    modport master (
        output CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
        input  MISO, tx_ready, rx_data, rx_valid, underrun, abort, busy
    );
endinterface

// File: rtl/spi_receptor_param.sv
// rtl/spi_receptor_param.sv - oversampling SPI slave, configurable width/words, optional SPI_LSB_FIRST_EN
module spi_receptor_param #(
    parameter int               WIDTH       = 16,
    parameter int               WORDS       = 2,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] DEFAULT_TX  = WIDTH'(16'h0106)
) (
    input logic                 clk,
    input logic                 reset,
    spi_receptor_param_if.slave bus
);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam int WCW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    state_t                 r_state;
    logic                   r_sample_rise;
    logic [BCW-1:0]         r_bit_cnt;
    logic [WCW-1:0]         r_word_cnt;
    logic [WIDTH-1:0]       r_rx_shift;
    logic [WIDTH-1:0]       r_tx_shift;
    logic [WIDTH-1:0]       r_tx_buf;
    logic                   r_tx_full;
    logic                   r_miso;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic                   r_abort;

    logic                   w_sck;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sample_edge;
    logic                   w_drive_edge;
    logic                   w_last_bit;
    logic                   w_boundary;
    logic                   w_reload;
    logic [WIDTH-1:0]       w_next_word;
    logic [WIDTH-1:0]       w_rx_next;
    logic                   w_tx_bit;
    logic [WIDTH-1:0]       w_tx_after;
    logic                   w_word_first;
    logic [WIDTH-1:0]       w_word_rest;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;

    // Mode was latched at CS fall; the drive edge is always the opposite SCK edge.
    assign w_sample_edge = r_sample_rise ? w_sck_rise : w_sck_fall;
    assign w_drive_edge  = r_sample_rise ? w_sck_fall : w_sck_rise;

    assign w_last_bit = (r_bit_cnt == BCW'(WIDTH - 1));
    assign w_boundary = (r_state == XFER) && !w_cs_rise && w_sample_edge && w_last_bit;
    // A new TX word is fetched at CS fall and at every boundary except the final one.
    assign w_reload   = ((r_state == IDLE) && w_cs_fall) ||
                        (w_boundary && (r_word_cnt != WCW'(WORDS - 1)));
    assign w_next_word = r_tx_full ? r_tx_buf : DEFAULT_TX;

`ifdef SPI_LSB_FIRST_EN
    assign w_rx_next    = {w_mosi, r_rx_shift[WIDTH-1:1]};
    assign w_tx_bit     = r_tx_shift[0];
    assign w_tx_after   = {1'b0, r_tx_shift[WIDTH-1:1]};
    assign w_word_first = w_next_word[0];
    assign w_word_rest  = {1'b0, w_next_word[WIDTH-1:1]};
`else
    assign w_rx_next    = {r_rx_shift[WIDTH-2:0], w_mosi};
    assign w_tx_bit     = r_tx_shift[WIDTH-1];
    assign w_tx_after   = {r_tx_shift[WIDTH-2:0], 1'b0};
    assign w_word_first = w_next_word[WIDTH-1];
    assign w_word_rest  = {w_next_word[WIDTH-2:0], 1'b0};
`endif

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.underrun = r_underrun;
    assign bus.abort    = r_abort;
    assign bus.tx_ready = ~r_tx_full;
    assign bus.busy     = (r_state != IDLE);

    // Pin synchronisers plus previous-sample flops for edge detection; CS idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.SCK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
        end
    end

    // TX buffer: a reload consumes a full buffer; loads only land in an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_reload & ~r_tx_full;
            if (w_reload && r_tx_full) begin
                r_tx_full <= 1'b0;
            end else if (bus.tx_load && !r_tx_full) begin
                r_tx_buf  <= bus.tx_data;
                r_tx_full <= 1'b1;
            end
        end
    end

    // Transfer FSM: shifts RX/TX bits on selected SCK edges and produces the strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sample_rise <= 1'b1;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_miso        <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_sample_rise <= (bus.CKP == bus.CPH);
                        r_bit_cnt     <= '0;
                        r_word_cnt    <= '0;
                        r_state       <= XFER;
                        if (!bus.CPH) begin
                            r_miso     <= w_word_first;
                            r_tx_shift <= w_word_rest;
                        end else begin
                            r_tx_shift <= w_next_word;
                        end
                    end
                end
                XFER: begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_miso    <= 1'b0;
                        r_abort   <= (r_bit_cnt != '0);
                        r_bit_cnt <= '0;
                    end else if (w_sample_edge) begin
                        r_rx_shift <= w_rx_next;
                        if (w_last_bit) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= r_word_cnt + WCW'(1);
                            if (r_word_cnt == WCW'(WORDS - 1)) begin
                                r_state <= DONE;
                            end else begin
                                r_tx_shift <= w_next_word;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end else if (w_drive_edge) begin
                        r_miso     <= w_tx_bit;
                        r_tx_shift <= w_tx_after;
                    end
                end
                DONE: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_receptor_param.sv
// tb/tb_spi_receptor_param.sv - randomized self-checking bench for spi_receptor_param
`timescale 1ns/1ps
module tb_spi_receptor_param;
    localparam int          W   = 16;
    localparam int          NW  = 2;
    localparam int          H   = 8;
    localparam logic [W-1:0] DEF = 16'h0106;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_receptor_param_if #(.WIDTH(W)) bus ();

    spi_receptor_param #(
        .WIDTH(W), .WORDS(NW), .SYNC_STAGES(2), .DEFAULT_TX(DEF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int un_cnt = 0;
    int ab_cnt = 0;
    logic [W-1:0] rx_q[$];

    logic         m_full;
    logic [W-1:0] m_buf;
    logic [W-1:0] m_last_rx;
    logic [63:0]  cap_before;
    logic [63:0]  cap_after;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) rx_q.push_back(bus.rx_data);
            if (bus.underrun) un_cnt++;
            if (bus.abort)    ab_cnt++;
        end
    end

    function automatic logic bit_of(input logic [W-1:0] w, input int j);
`ifdef SPI_LSB_FIRST_EN
        return w[j];
`else
        return w[W-1-j];
`endif
    endfunction

    function automatic logic mb(input logic [63:0] m, input int i, input int nbits);
        logic [W-1:0] wd;
        if (i >= nbits) return 1'b0;
        wd = m[63 - W*(i/W) -: W];
        return bit_of(wd, i % W);
    endfunction

    task automatic load_word(input logic [W-1:0] v);
        @(negedge clk);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
    endtask

    task automatic sample_edge(input logic lvl, input int i, input int load_at, input logic [W-1:0] lval);
        cap_before[63-i] = bus.MISO;
        bus.SCK = lvl;
        repeat (2) @(negedge clk);
        if (i == load_at) begin
            bus.tx_data = lval;
            bus.tx_load = 1'b1;
        end
        @(negedge clk);
        bus.tx_load = 1'b0;
        @(negedge clk);
        cap_after[63-i] = bus.MISO;
        repeat (H-4) @(negedge clk);
    endtask

    task automatic xfer(input logic ckp, input logic cph, input int nbits, input logic [63:0] mosi,
                        input int load_at, input logic [W-1:0] lval, input string tag);
        logic [W-1:0] words[NW];
        logic [63:0]  exp_miso;
        logic [W-1:0] got_rx;
        int           done_w, loaded, exp_un, rx0, un0, ab0, ii;
        logic         exp_ab, exp_rdy_fall, was_full;

        done_w = (nbits / W < NW) ? nbits / W : NW;
        loaded = (done_w == NW) ? NW : done_w + 1;
        exp_un = 0;
        exp_rdy_fall = 1'b1;
        for (int k = 0; k < loaded; k++) begin
            was_full = m_full;
            if (m_full) begin
                words[k] = m_buf;
                m_full = 1'b0;
            end else begin
                words[k] = DEF;
                exp_un++;
            end
            if (k == 0) exp_rdy_fall = !m_full;
            if (k > 0 && load_at == k*W - 1 && !was_full) begin
                m_full = 1'b1;
                m_buf  = lval;
            end
        end
        for (int k = loaded; k < NW; k++) words[k] = '0;
        exp_miso = '0;
        for (int i = 0; i < nbits; i++) begin
            ii = (i < NW*W) ? i : NW*W - 1;
            exp_miso[63-i] = bit_of(words[ii/W], ii % W);
        end
        exp_ab = (nbits % W != 0) && (nbits < NW*W);

        rx0 = rx_q.size();
        un0 = un_cnt;
        ab0 = ab_cnt;
        cap_before = '0;
        cap_after  = '0;

        bus.CKP = ckp;
        bus.CPH = cph;
        bus.SCK = ckp;
        repeat (4) @(negedge clk);
        bus.CS = 1'b0;
        if (!cph) bus.MOSI = mb(mosi, 0, nbits);
        repeat (H) @(negedge clk);
        check({tag, "_busy_hi"}, 64'(bus.busy), 64'(1));
        check({tag, "_rdy_fall"}, 64'(bus.tx_ready), 64'(exp_rdy_fall));
        for (int i = 0; i < nbits; i++) begin
            if (cph) begin
                bus.SCK  = ~ckp;
                bus.MOSI = mb(mosi, i, nbits);
                repeat (H) @(negedge clk);
                sample_edge(ckp, i, load_at, lval);
            end else begin
                sample_edge(~ckp, i, load_at, lval);
                bus.SCK  = ckp;
                bus.MOSI = mb(mosi, i + 1, nbits);
                repeat (H) @(negedge clk);
            end
        end
        bus.CS = 1'b1;
        repeat (8) @(negedge clk);

        check({tag, "_miso"}, cap_before, exp_miso);
        check({tag, "_miso_hold"}, cap_after, exp_miso);
        check({tag, "_rx_cnt"}, 64'(rx_q.size() - rx0), 64'(done_w));
        for (int k = 0; k < done_w; k++) begin
            got_rx = (rx0 + k < rx_q.size()) ? rx_q[rx0 + k] : 'x;
            check({tag, "_rx_word"}, 64'(got_rx), 64'(mosi[63 - W*k -: W]));
        end
        if (done_w > 0) m_last_rx = mosi[63 - W*(done_w-1) -: W];
        check({tag, "_underrun"}, 64'(un_cnt - un0), 64'(exp_un));
        check({tag, "_abort"}, 64'(ab_cnt - ab0), 64'(exp_ab));
        check({tag, "_rx_data"}, 64'(bus.rx_data), 64'(m_last_rx));
        check({tag, "_miso_idle"}, 64'(bus.MISO), 64'(0));
        check({tag, "_busy_lo"}, 64'(bus.busy), 64'(0));
        check({tag, "_rdy_end"}, 64'(bus.tx_ready), 64'(!m_full));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_miso"}, 64'(bus.MISO), 64'(0));
        check({tag, "_rx_data"}, 64'(bus.rx_data), 64'(0));
        check({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'(0));
        check({tag, "_underrun"}, 64'(bus.underrun), 64'(0));
        check({tag, "_abort"}, 64'(bus.abort), 64'(0));
        check({tag, "_tx_ready"}, 64'(bus.tx_ready), 64'(1));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rm;
        logic        rckp, rcph;
        int          sel, nb;

        reset = 1'b1;
        bus.CKP = 1'b0; bus.CPH = 1'b0; bus.SCK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0;
        bus.tx_data = '0; bus.tx_load = 1'b0;
        m_full = 1'b0; m_buf = '0; m_last_rx = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_state("rst_rel");

        // mode 0, empty buffer, two words
        xfer(1'b0, 1'b0, 32, {16'hA5C3, 16'h1234, 32'h0}, -1, '0, "m0");

        // mode 3 with preloaded word; second load while full must be ignored
        load_word(16'hBEEF);
        load_word(16'h2222);
        check("m3_rdy_full", 64'(bus.tx_ready), 64'(!m_full));
        xfer(1'b1, 1'b1, 16, {16'h00FF, 48'h0}, -1, '0, "m3");

        // modes 1 and 2
        xfer(1'b0, 1'b1, 16, {16'h8001, 48'h0}, -1, '0, "m1");
        xfer(1'b1, 1'b0, 16, {16'h8001, 48'h0}, -1, '0, "m2");

        // abort after 7 bits, then a clean word
        xfer(1'b0, 1'b0, 7, {16'hFFFF, 48'h0}, -1, '0, "abort");
        xfer(1'b0, 1'b0, 16, {16'h5555, 48'h0}, -1, '0, "post_abort");

        // overlong transaction: extra edges ignored in DONE
        xfer(1'b0, 1'b0, 40, {16'h3C3C, 16'hC3C3, 16'hFFFF, 16'h0}, -1, '0, "over");

        // load coinciding with the first word boundary, buffer empty
        xfer(1'b0, 1'b0, 32, {16'hA5A5, 16'h5A5A, 32'h0}, 15, 16'h1111, "bload");
        xfer(1'b0, 1'b0, 16, {16'h0F0F, 48'h0}, -1, '0, "after_bload");

        // asynchronous reset in the middle of a transfer
        bus.CKP = 1'b0; bus.CPH = 1'b0; bus.SCK = 1'b0;
        repeat (4) @(negedge clk);
        bus.CS = 1'b0;
        repeat (H) @(negedge clk);
        bus.SCK = 1'b1; repeat (H) @(negedge clk);
        bus.SCK = 1'b0; repeat (H) @(negedge clk);
        bus.SCK = 1'b1;
        m_full = 1'b0;
        load_word(16'h7777);
        check("midrst_rdy", 64'(bus.tx_ready), 64'(!m_full));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        bus.CS = 1'b1; bus.SCK = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        m_full = 1'b0; m_last_rx = '0;
        repeat (4) @(negedge clk);

        // randomized transactions against the model
        for (int t = 0; t < 24; t++) begin
            rckp = 1'($urandom % 2);
            rcph = 1'($urandom % 2);
            sel  = int'($urandom % 4);
            case (sel)
                0:       nb = 32;
                1:       nb = 16;
                2:       nb = 33 + int'($urandom % 12);
                default: nb = 1 + int'($urandom % 31);
            endcase
            rm = {$urandom, $urandom};
            if ($urandom % 2 == 0) load_word(16'($urandom));
            if ($urandom % 4 == 0) load_word(16'($urandom));
            xfer(rckp, rcph, nb, rm, -1, '0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
